// File: rtl/arbitro_registro_if.sv
// arbitro_registro_if -- bus bundle between three requesters, the arbiter and
// the register file.
//
// Signals
//   req, req_wr            per-requester request level and write flag (3 bits)
//   req_index, req_wdata   per-requester command fields, requester k at
//                          [k*W +: W]
//   gnt, ack               one-hot grant and one-cycle completion pulse
//   rdata                  last completed read data
//   reg_wr_en, reg_rd_en   one-cycle command pulses to the register file
//   reg_index, reg_wdata   latched command fields to the register file
//   reg_rd_valid, reg_rd_data  register-file read response
//   busy, timeout_err      arbiter status
//
// Modports
//   master  environment side (requesters + register file), drives the inputs
//   slave   arbiter side
interface arbitro_registro_if #(
  parameter int INDEX_W = 5,
  parameter int DATA_W  = 16
);
  logic [2:0]           req;
  logic [2:0]           req_wr;
  logic [3*INDEX_W-1:0] req_index;
  logic [3*DATA_W-1:0]  req_wdata;
  logic [2:0]           gnt;
  logic [2:0]           ack;
  logic [DATA_W-1:0]    rdata;
  logic                 reg_wr_en;
  logic                 reg_rd_en;
  logic [INDEX_W-1:0]   reg_index;
  logic [DATA_W-1:0]    reg_wdata;
  logic                 reg_rd_valid;
  logic [DATA_W-1:0]    reg_rd_data;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req, req_wr, req_index, req_wdata, reg_rd_valid, reg_rd_data,
    input  gnt, ack, rdata, reg_wr_en, reg_rd_en, reg_index, reg_wdata,
           busy, timeout_err
  );

  modport slave (
    input  req, req_wr, req_index, req_wdata, reg_rd_valid, reg_rd_data,
    output gnt, ack, rdata, reg_wr_en, reg_rd_en, reg_index, reg_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/arbitro_registro.sv
// arbitro_registro -- round-robin arbiter giving three requesters (0 = LFSR
// writer, 1 = ALU reader, 2 = Display reader) single-transaction access to a
// register file.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    arbitro_registro_if.slave: requests, grant/ack, register-file
//          command and response, busy and timeout_err status
//
// Parameters
//   TIMEOUT_CYC  WAIT cycles before an unanswered read is aborted (2..255)
//   INDEX_W      register index width
//   DATA_W       register data width
//
// Build option
//   ARBITRO_TIMEOUT_EN  when defined, a read with no reg_rd_valid for
//                       TIMEOUT_CYC WAIT cycles completes with rdata=0 and
//                       sets the sticky timeout_err; when undefined, WAIT
//                       holds until reg_rd_valid and timeout_err is 0.
//
// Every output is a flop. Each is loaded from the next-state decode, so the
// output value lines up with the state it belongs to.
module arbitro_registro #(
  parameter int TIMEOUT_CYC = 16,
  parameter int INDEX_W     = 5,
  parameter int DATA_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  arbitro_registro_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [1:0]         last_winner_r;
  logic [1:0]         winner_r;
  logic [1:0]         next_winner_s;
  logic [1:0]         pick_s;
  logic               any_req_s;
  logic               start_s;
  logic               rd_capture_s;
  logic               timeout_hit_s;

  logic [2:0]         gnt_r;
  logic [2:0]         ack_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               reg_wr_en_r;
  logic               reg_rd_en_r;
  logic [INDEX_W-1:0] reg_index_r;
  logic [DATA_W-1:0]  reg_wdata_r;
  logic               busy_r;

  // Requester number to one-hot grant vector.
  function automatic logic [2:0] onehot3(input logic [1:0] w);
    logic [2:0] v;
    case (w)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Round-robin search starting just after the previous winner.
  function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [2:0] r);
    logic [1:0] w;
    case (last)
      2'd0: begin
        if (r[1])      w = 2'd1;
        else if (r[2]) w = 2'd2;
        else           w = 2'd0;
      end
      2'd1: begin
        if (r[2])      w = 2'd2;
        else if (r[0]) w = 2'd0;
        else           w = 2'd1;
      end
      default: begin
        if (r[0])      w = 2'd0;
        else if (r[1]) w = 2'd1;
        else           w = 2'd2;
      end
    endcase
    return w;
  endfunction

  assign any_req_s    = |bus.req;
  assign pick_s       = rr_next(last_winner_r, bus.req);
  assign start_s      = (state_r == ST_IDLE) && any_req_s;
  // A response is only meaningful while a read is outstanding.
  assign rd_capture_s = (state_r == ST_WAIT) && bus.reg_rd_valid;

`ifdef ARBITRO_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
  logic       timeout_err_r;

  assign timeout_hit_s = (state_r == ST_WAIT) && !bus.reg_rd_valid &&
                         (wait_cnt_r == 8'(TIMEOUT_CYC - 1));

  // WAIT-cycle counter; ISSUE always precedes WAIT, so clearing there
  // restarts the count on every read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r == ST_ISSUE) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign bus.timeout_err = timeout_err_r;
`else
  assign timeout_hit_s   = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state and next-winner decode.
  always_comb begin
    next_state_s  = state_r;
    next_winner_s = winner_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s  = ST_ISSUE;
          next_winner_s = pick_s;
        end else begin
          next_state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.reg_wr_en) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.reg_rd_valid || timeout_hit_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, winner and handshake outputs, all loaded from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      winner_r      <= 2'd0;
      last_winner_r <= 2'd2;
      gnt_r         <= 3'b000;
      ack_r         <= 3'b000;
      busy_r        <= 1'b0;
      reg_wr_en_r   <= 1'b0;
      reg_rd_en_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      winner_r    <= next_winner_s;
      gnt_r       <= (next_state_s != ST_IDLE) ? onehot3(next_winner_s) : 3'b000;
      ack_r       <= (next_state_s == ST_DONE) ? onehot3(next_winner_s) : 3'b000;
      busy_r      <= (next_state_s != ST_IDLE);
      // ISSUE is only ever entered from IDLE, so the start cycle decides the pulse.
      reg_wr_en_r <= start_s && bus.req_wr[pick_s];
      reg_rd_en_r <= start_s && !bus.req_wr[pick_s];
      if (state_r == ST_DONE) begin
        last_winner_r <= winner_r;
      end else begin
        last_winner_r <= last_winner_r;
      end
    end
  end

  // Command fields are captured at arbitration and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_index_r <= {INDEX_W{1'b0}};
      reg_wdata_r <= {DATA_W{1'b0}};
    end else if (start_s) begin
      reg_index_r <= bus.req_index[int'(pick_s)*INDEX_W +: INDEX_W];
      reg_wdata_r <= bus.req_wdata[int'(pick_s)*DATA_W +: DATA_W];
    end else begin
      reg_index_r <= reg_index_r;
      reg_wdata_r <= reg_wdata_r;
    end
  end

  // Read data register: updates only on read completion (response or timeout).
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (rd_capture_s) begin
      rdata_r <= bus.reg_rd_data;
    end else if (timeout_hit_s) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.ack       = ack_r;
  assign bus.rdata     = rdata_r;
  assign bus.reg_wr_en = reg_wr_en_r;
  assign bus.reg_rd_en = reg_rd_en_r;
  assign bus.reg_index = reg_index_r;
  assign bus.reg_wdata = reg_wdata_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_arbitro_registro.sv
// tb_arbitro_registro -- self-checking bench for arbitro_registro.
// A transaction-level reference (round-robin by modular search, expected
// per-cycle timeline of each transaction) predicts every output; stimulus
// (request patterns, command fields, response delay, stray responses, req
// drops) is drawn with $urandom.
module tb_arbitro_registro;
  localparam int TIMEOUT_CYC = 16;
  localparam int INDEX_W     = 5;
  localparam int DATA_W      = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state
  int                last_m;
  logic [DATA_W-1:0] rdata_m;
  logic              terr_m;

  arbitro_registro_if #(.INDEX_W(INDEX_W), .DATA_W(DATA_W)) bus ();

  arbitro_registro #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .INDEX_W(INDEX_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [2:0] r);
    int sel;
    sel = -1;
    for (int i = 1; i <= 3; i++) begin
      if (sel < 0 && r[(last + i) % 3]) sel = (last + i) % 3;
    end
    return sel;
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_gnt"},   64'(bus.gnt), 64'd0);
    check_val({tag, "_ack"},   64'(bus.ack), 64'd0);
    check_val({tag, "_busy"},  64'(bus.busy), 64'd0);
    check_val({tag, "_wren"},  64'(bus.reg_wr_en), 64'd0);
    check_val({tag, "_rden"},  64'(bus.reg_rd_en), 64'd0);
    check_val({tag, "_rdata"}, 64'(bus.rdata), 64'(rdata_m));
    check_val({tag, "_terr"},  64'(bus.timeout_err), 64'(terr_m));
  endtask

  task automatic check_reset_vals(input string tag);
    check_quiet(tag);
    check_val({tag, "_idx"}, 64'(bus.reg_index), 64'd0);
    check_val({tag, "_wd"},  64'(bus.reg_wdata), 64'd0);
  endtask

  // One complete transaction started from an IDLE cycle.
  task automatic run_txn(input logic [2:0] r, input logic [2:0] wrs, input int delay,
                         input bit stray, input bit drop);
    logic [INDEX_W-1:0] idx_a [3];
    logic [DATA_W-1:0]  wd_a [3];
    logic [DATA_W-1:0]  rd;
    logic [2:0]         oh;
    int                 w;
    for (int k = 0; k < 3; k++) begin
      idx_a[k] = INDEX_W'($urandom);
      wd_a[k]  = DATA_W'($urandom);
      bus.req_index[k*INDEX_W +: INDEX_W] = idx_a[k];
      bus.req_wdata[k*DATA_W +: DATA_W]   = wd_a[k];
    end
    bus.req    = r;
    bus.req_wr = wrs;
    if (stray) begin
      bus.reg_rd_valid = 1'b1;
      bus.reg_rd_data  = DATA_W'($urandom);
    end
    w  = rr_pick(last_m, r);
    oh = 3'b001 << w;
    step();
    bus.reg_rd_valid = 1'b0;
    // ISSUE cycle
    check_val("issue_gnt",   64'(bus.gnt), 64'(oh));
    check_val("issue_ack",   64'(bus.ack), 64'd0);
    check_val("issue_busy",  64'(bus.busy), 64'd1);
    check_val("issue_wren",  64'(bus.reg_wr_en), 64'(wrs[w]));
    check_val("issue_rden",  64'(bus.reg_rd_en), 64'(!wrs[w]));
    check_val("issue_idx",   64'(bus.reg_index), 64'(idx_a[w]));
    check_val("issue_wdata", 64'(bus.reg_wdata), 64'(wd_a[w]));
    check_val("issue_rdata", 64'(bus.rdata), 64'(rdata_m));
    if (drop) bus.req = 3'($urandom) & ~oh;
    if (wrs[w]) begin
      step();
      check_val("wdone_ack",   64'(bus.ack), 64'(oh));
      check_val("wdone_gnt",   64'(bus.gnt), 64'(oh));
      check_val("wdone_wren",  64'(bus.reg_wr_en), 64'd0);
      check_val("wdone_rdata", 64'(bus.rdata), 64'(rdata_m));
    end else begin
      rd = DATA_W'($urandom);
      for (int k = 0; k <= delay; k++) begin
        step();
        check_val("wait_gnt",   64'(bus.gnt), 64'(oh));
        check_val("wait_ack",   64'(bus.ack), 64'd0);
        check_val("wait_busy",  64'(bus.busy), 64'd1);
        check_val("wait_rden",  64'(bus.reg_rd_en), 64'd0);
        check_val("wait_rdata", 64'(bus.rdata), 64'(rdata_m));
        if (k == delay) begin
          bus.reg_rd_valid = 1'b1;
          bus.reg_rd_data  = rd;
        end
      end
      step();
      bus.reg_rd_valid = 1'b0;
      rdata_m = rd;
      check_val("rdone_ack",   64'(bus.ack), 64'(oh));
      check_val("rdone_gnt",   64'(bus.gnt), 64'(oh));
      check_val("rdone_rdata", 64'(bus.rdata), 64'(rdata_m));
    end
    last_m = w;
    step();
    check_quiet("post");
    check_val("hold_idx", 64'(bus.reg_index), 64'(idx_a[w]));
    check_val("hold_wd",  64'(bus.reg_wdata), 64'(wd_a[w]));
  endtask

  initial begin
    reset            = 1'b1;
    bus.req          = 3'b000;
    bus.req_wr       = 3'b000;
    bus.req_index    = '0;
    bus.req_wdata    = '0;
    bus.reg_rd_valid = 1'b0;
    bus.reg_rd_data  = '0;
    last_m  = 2;
    rdata_m = '0;
    terr_m  = 1'b0;
    step();
    step();
    check_reset_vals("rst");
    reset = 1'b0;
    step();
    check_reset_vals("rst_idle");

    // All three requesting continuously: rotation 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++) begin
      run_txn(3'b111, 3'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // Random traffic with idle gaps, stray responses and req drops.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req          = 3'b000;
        bus.reg_rd_valid = 1'b1;
        bus.reg_rd_data  = DATA_W'($urandom);
        step();
        bus.reg_rd_valid = 1'b0;
        check_quiet("gap");
      end
      run_txn(3'($urandom_range(1, 7)), 3'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    // Read that never gets a response.
    bus.req    = 3'b010;
    bus.req_wr = 3'b000;
    step();
    check_val("to_issue_rden", 64'(bus.reg_rd_en), 64'd1);
    bus.req = 3'b000;
`ifdef ARBITRO_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      step();
      check_val("to_wait_busy", 64'(bus.busy), 64'd1);
      check_val("to_wait_ack",  64'(bus.ack), 64'd0);
      check_val("to_wait_terr", 64'(bus.timeout_err), 64'd0);
    end
    step();
    rdata_m = '0;
    terr_m  = 1'b1;
    check_val("to_ack",   64'(bus.ack), 64'(3'b010));
    check_val("to_rdata", 64'(bus.rdata), 64'd0);
    check_val("to_terr",  64'(bus.timeout_err), 64'd1);
    last_m = 1;
    step();
    check_quiet("to_post");
    run_txn(3'b001, 3'b001, 0, 1'b0, 1'b0);
`else
    for (int k = 0; k < 40; k++) begin
      step();
      check_val("hold_busy", 64'(bus.busy), 64'd1);
      check_val("hold_gnt",  64'(bus.gnt), 64'(3'b010));
      check_val("hold_ack",  64'(bus.ack), 64'd0);
      check_val("hold_terr", 64'(bus.timeout_err), 64'd0);
    end
    bus.reg_rd_valid = 1'b1;
    bus.reg_rd_data  = 16'h00ab;
    step();
    bus.reg_rd_valid = 1'b0;
    rdata_m = 16'h00ab;
    check_val("late_ack",   64'(bus.ack), 64'(3'b010));
    check_val("late_rdata", 64'(bus.rdata), 64'(rdata_m));
    last_m = 1;
    step();
    check_quiet("late_post");
`endif

    // Reset in the middle of a read.
    bus.req    = 3'b100;
    bus.req_wr = 3'b000;
    step();
    check_val("mr_issue_gnt", 64'(bus.gnt), 64'(3'b100));
    step();
    step();
    check_val("mr_wait_gnt", 64'(bus.gnt), 64'(3'b100));
    reset = 1'b1;
    step();
    last_m  = 2;
    rdata_m = '0;
    terr_m  = 1'b0;
    check_reset_vals("mr_rst");
    reset   = 1'b0;
    bus.req = 3'b000;
    step();
    check_reset_vals("mr_after");

    for (int i = 0; i < 10; i++) begin
      run_txn(3'($urandom_range(1, 7)), 3'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arbitro_registro.md
ARBITRO_REGISTRO -- requirements
Module: arbitro_registro

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: WAIT-state cycles before a read is aborted (legal range 2..255).
REQ-002 Parameter INDEX_W, default 5: register index width.
REQ-003 Parameter DATA_W, default 16: register data width.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  request level per requester (0 = LFSR writer, 1 = ALU reader, 2 = Display reader).
REQ-007 req_wr  input  3  per requester: 1 = write, 0 = read.
REQ-008 req_index  input  3*INDEX_W  per-requester index; requester k occupies bits [k*INDEX_W +: INDEX_W].
REQ-009 req_wdata  input  3*DATA_W  per-requester write data, packed the same way.
REQ-010 gnt  output  3  one-hot grant; high for the whole transaction.
REQ-011 ack  output  3  one-cycle completion pulse to the winning requester.
REQ-012 rdata  output  DATA_W  last completed read data.
REQ-013 reg_wr_en / reg_rd_en  output  1 each  one-cycle command pulses to the register file.
REQ-014 reg_index  output  INDEX_W; reg_wdata  output  DATA_W  latched command fields.
REQ-015 reg_rd_valid  input  1; reg_rd_data  input  DATA_W  register-file read response.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 timeout_err  output  1  sticky read-timeout flag.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE; state is registered.
REQ-019 IDLE: if any req bit is high, select a winner round-robin, searching from (last_winner+1) mod 3; latch its wr, index and wdata; go to ISSUE.
REQ-020 ISSUE (exactly one cycle): gnt[winner]=1; pulse reg_wr_en if wr, else reg_rd_en; next state is DONE for a write, WAIT for a read.
REQ-021 WAIT: on reg_rd_valid, capture reg_rd_data into rdata and go to DONE; gnt stays high.
REQ-022 DONE: ack[winner]=1 for one cycle; gnt drops at the end of DONE; last_winner<=winner; next state IDLE.
REQ-023 Latency for a req first seen in IDLE at cycle N: ISSUE at N+1. Write: ack at N+2. Read: ack one cycle after the cycle in which reg_rd_valid is seen.
REQ-024 A new arbitration occurs no earlier than the cycle after DONE; no back-to-back issue.
REQ-025 Deasserting req mid-transaction does not abort the transaction; ack still pulses.
REQ-026 req held high after ack is re-arbitrated; the other two requesters take priority if they are pending.
REQ-027 reg_rd_valid outside WAIT is ignored.
REQ-028 reg_index and reg_wdata hold their latched values until the next ISSUE.
REQ-029 rdata changes only on read completion; a write leaves rdata unchanged.
REQ-030 gnt and ack are never high for more than one requester.

Reset
REQ-031 On reset: state=IDLE, last_winner=2 (so requester 0 wins first), gnt=0, ack=0, rdata=0, reg_wr_en=0, reg_rd_en=0, reg_index=0, reg_wdata=0, busy=0, timeout_err=0, timeout counter=0.
REQ-032 Reset asserted mid-transaction aborts it: no ack is issued and the next cycle is IDLE with reset values.

Configuration
REQ-033 Macro ARBITRO_TIMEOUT_EN defined: WAIT counts cycles; after TIMEOUT_CYC cycles without reg_rd_valid, go to DONE with rdata=0, ack pulsed and timeout_err set; timeout_err clears only on reset; the counter clears on entry to WAIT.
REQ-034 Macro ARBITRO_TIMEOUT_EN undefined: WAIT holds until reg_rd_valid with no counter; timeout_err is tied to 0.

Verification
REQ-035 Single write: reset, then req=001, req_wr=001, index0=3, wdata0=0x1234 -> gnt=001 and reg_wr_en=1 with reg_index=3, reg_wdata=0x1234 at N+1; ack=001 at N+2; busy=0 at N+3.
REQ-036 Read: req=010, index1=7; reg_rd_valid with data 0x00AB two cycles after ISSUE -> rdata=0x00AB and ack=010 one cycle later; gnt=010 throughout.
REQ-037 Round-robin fairness: req=111 held constantly after reset -> grant order 0,1,2,0,1,2; each ack exactly once per rotation.
REQ-038 Mid-transaction events: requester 2 drops req during WAIT -> ack still pulses. Reset asserted during WAIT -> no ack, all outputs at reset values the next cycle.
REQ-039 Timeout (ARBITRO_TIMEOUT_EN defined, TIMEOUT_CYC=16): read with no reg_rd_valid -> ack after 16 WAIT cycles, rdata=0, timeout_err=1 and held. Same test without the macro -> the FSM stays in WAIT.
REQ-040 Stray response: reg_rd_valid pulsed in IDLE -> rdata unchanged and no ack.
